note_pattern_loader: RTL and testbench
======================================

Name: note_pattern_loader

Overview:
Byte-stream writer that fills the note pattern RAM read by the channel note sequencers. The sequencer reads 16-bit entries at 5-bit addresses, with note in bits [5:0] and length in bits [10:6]. Accepts framed pattern uploads on a valid/ready byte interface, writes each entry to the RAM write port, and validates the frame with a checksum. Holds the downstream sequencer off while the pattern is being rewritten and publishes the pattern length on success.

Parameters:
ADDR_WIDTH, 5, RAM address width; max entries DEPTH = 2**ADDR_WIDTH (32).
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 1000000, max idle clocks between bytes inside a frame before abort; must be >= 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_byte  in  8  stream data
i_byte_valid  in  1  i_byte valid this cycle
o_byte_ready  out  1  loader accepts i_byte; transfer = valid & ready
o_wr_en  out  1  one-cycle RAM write strobe
o_wr_addr  out  ADDR_WIDTH  RAM write address
o_wr_data  out  16  RAM write data {hi byte, lo byte}
o_seq_hold  out  1  sequencer must hold in reset while high
o_pattern_valid  out  1  RAM holds a complete, checksum-verified pattern
o_pattern_last  out  ADDR_WIDTH  index of last valid entry (N-1)
o_done_stb  out  1  one-cycle pulse on successful frame
o_error  out  1  sticky error flag; cleared on next accepted sync

Behaviour:
- Clock i_clk; reset i_rst is synchronous and active-high.
- Frame format, in order:
  - SYNC_BYTE.
  - Count N, valid range 1..DEPTH.
  - N entries, each lo byte then hi byte.
  - Checksum C = 8-bit modular sum of the count byte and all 2N entry bytes.
- States and transitions:
  - IDLE: non-sync bytes are accepted and discarded. Sync -> COUNT.
  - COUNT: N==0 or N>DEPTH -> error, IDLE. Otherwise latch N, addr=0 -> LO.
  - LO: latch lo byte -> HI.
  - HI: latch hi byte -> WRITE.
  - WRITE: one cycle. o_wr_en=1, o_wr_addr=addr, o_wr_data={hi,lo}. If addr==N-1 -> CSUM, else addr+1 -> LO.
  - CSUM: byte==running sum -> success, IDLE. Mismatch -> error, IDLE.
- o_byte_ready is combinational from state: 1 in all states except WRITE, where it is 0.
- Write latency: the o_wr_en pulse occurs exactly one cycle after the HI byte transfer. o_wr_en is 0 in every other state.
- Entry bits [15:11] are written unmodified; the loader does no field checking.
- On sync accepted, in the same edge:
  - o_seq_hold <= 1
  - o_pattern_valid <= 0
  - o_error <= 0
  - running sum <= 0
- On success:
  - o_seq_hold <= 0
  - o_pattern_valid <= 1
  - o_pattern_last <= N-1
  - o_done_stb pulses 1 cycle
- On error (bad count, checksum mismatch, timeout):
  - o_error <= 1
  - o_seq_hold <= 0
  - o_pattern_valid stays 0
  - o_pattern_last unchanged
- Timeout:
  - An idle counter runs in every state except IDLE and WRITE.
  - It is cleared on each transfer and on entry to those states.
  - Reaching TIMEOUT_CYCLES -> error, IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- A SYNC_BYTE value received mid-frame is data, not a restart.
- Reset values: state IDLE, o_byte_ready 1, o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_seq_hold 0, o_pattern_valid 0, o_pattern_last 0, o_done_stb 0, o_error 0.
- Reset mid-frame: abort immediately. No further writes occur, and outputs take their reset values.

Test Plan:
- A5, 01, 23, 01, 25 with valid held high -> single o_wr_en with addr 0, data 16'h0123, one cycle after the 01 hi byte. o_byte_ready=0 that cycle. o_done_stb pulses, o_pattern_valid=1, o_pattern_last=0, o_seq_hold high from the cycle after A5 until done.
- Full 32-entry frame (entry k = 16'h0040|k), correct checksum -> 32 writes at addr 0..31 in order, o_pattern_last=31, no error.
- Count byte 00, then separately count 21 (33) -> o_error=1, no writes, return to IDLE; a following valid frame clears o_error and succeeds.
- Correct frame with checksum+1 -> all entries written, o_error=1, o_pattern_valid=0, o_done_stb never pulses.
- Leading garbage (00, FF, 12) before A5 with random i_byte_valid gaps -> garbage discarded, frame loads identically to the gap-free case.
- Stall TIMEOUT_CYCLES after the count byte -> o_error=1, IDLE. Separately, assert i_rst after the 3rd entry -> no further o_wr_en, and all outputs read their reset values on the next cycle.

Source files
------------

// File: rtl/note_pattern_loader.sv
// note_pattern_loader
//   Loads the note pattern RAM that the channel note sequencers read. It
//   receives framed uploads on a byte stream:
//     SYNC_BYTE, count N (1..DEPTH), N x {lo, hi}, checksum.
//   The checksum is the 8-bit modular sum of the count byte and all entry
//   bytes. Each entry is written to the RAM write port one cycle after its
//   hi byte arrives. The sequencers are held off while the pattern is being
//   rewritten. The pattern length is published only after the checksum has
//   been verified.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_byte            stream data
//   i_byte_valid      i_byte valid this cycle
//   o_byte_ready      loader accepts i_byte (low only during a RAM write)
//   o_wr_en           one-cycle RAM write strobe
//   o_wr_addr         RAM write address
//   o_wr_data         RAM write data {hi, lo}
//   o_seq_hold        sequencers held in reset while high
//   o_pattern_valid   RAM holds a complete, verified pattern
//   o_pattern_last    index of the last valid entry (N-1)
//   o_done_stb        one-cycle pulse on a successful frame
//   o_error           sticky error flag, cleared by the next accepted sync
module note_pattern_loader #(
    parameter int         ADDR_WIDTH     = 5,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [15:0]           o_wr_data,
    output logic                  o_seq_hold,
    output logic                  o_pattern_valid,
    output logic [ADDR_WIDTH-1:0] o_pattern_last,
    output logic                  o_done_stb,
    output logic                  o_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_LO,
        S_HI,
        S_WRITE,
        S_CSUM
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] n_last;
    logic [7:0]            lo_byte;
    logic [7:0]            sum;
    logic [TW-1:0]         idle_cnt;

    logic xfer;
    logic count_ok;
    logic timer_on;
    logic timed_out;
    logic err_now;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign o_byte_ready = (state != S_WRITE);
    assign xfer         = i_byte_valid && o_byte_ready;
    assign count_ok     = (i_byte != 8'd0) && ({1'b0, i_byte} <= 9'(DEPTH));
    assign timer_on     = (state == S_COUNT) || (state == S_LO) ||
                          (state == S_HI)    || (state == S_CSUM);
    // T consecutive idle clocks in a timed state abort the frame.
    assign timed_out    = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        err_now = 1'b0;
        if (state == S_COUNT && xfer && !count_ok)
            err_now = 1'b1;
        if (state == S_CSUM && xfer && (i_byte != sum))
            err_now = 1'b1;
        if (timer_on && !xfer && timed_out)
            err_now = 1'b1;
    end

    // Control state and published outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= S_IDLE;
            addr            <= '0;
            idle_cnt        <= '0;
            o_wr_en         <= 1'b0;
            o_wr_addr       <= '0;
            o_wr_data       <= '0;
            o_seq_hold      <= 1'b0;
            o_pattern_valid <= 1'b0;
            o_pattern_last  <= '0;
            o_done_stb      <= 1'b0;
            o_error         <= 1'b0;
        end else begin
            o_wr_en    <= 1'b0;
            o_done_stb <= 1'b0;

            if (!timer_on || xfer)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (err_now) begin
                o_error    <= 1'b1;
                o_seq_hold <= 1'b0;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Anything other than sync is discarded here.
                        if (xfer && i_byte == SYNC_BYTE) begin
                            o_seq_hold      <= 1'b1;
                            o_pattern_valid <= 1'b0;
                            o_error         <= 1'b0;
                            state           <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (xfer) begin
                            addr  <= '0;
                            state <= S_LO;
                        end
                    end
                    S_LO: begin
                        if (xfer)
                            state <= S_HI;
                    end
                    S_HI: begin
                        if (xfer) begin
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= addr;
                            o_wr_data <= {i_byte, lo_byte};
                            state     <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (addr == n_last) begin
                            state <= S_CSUM;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= S_LO;
                        end
                    end
                    S_CSUM: begin
                        // Mismatch is handled by err_now above.
                        if (xfer) begin
                            o_seq_hold      <= 1'b0;
                            o_pattern_valid <= 1'b1;
                            o_pattern_last  <= n_last;
                            o_done_stb      <= 1'b1;
                            state           <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Frame data capture: lo byte, entry count and running checksum
    always_ff @(posedge i_clk) begin
        if (xfer) begin
            case (state)
                S_IDLE:  sum <= 8'd0;
                S_COUNT: begin
                    sum    <= csum_add(sum, i_byte);
                    n_last <= ADDR_WIDTH'(i_byte - 8'd1);
                end
                S_LO: begin
                    lo_byte <= i_byte;
                    sum     <= csum_add(sum, i_byte);
                end
                S_HI:    sum <= csum_add(sum, i_byte);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_note_pattern_loader.sv
module tb_note_pattern_loader;

    localparam int AW   = 5;
    localparam int TOUT = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    i_byte = 8'h00;
    logic          i_byte_valid = 1'b0;
    logic          o_byte_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [15:0]   o_wr_data;
    logic          o_seq_hold;
    logic          o_pattern_valid;
    logic [AW-1:0] o_pattern_last;
    logic          o_done_stb;
    logic          o_error;

    int total  = 0;
    int passed = 0;
    int done_cnt = 0;
    logic [20:0] exp_q[$];

    typedef struct {
        logic [7:0]  n;
        logic [15:0] base;
        logic [7:0]  adj;
        bit          garbage;
        bit          gaps;
        bit          exp_err;
        bit          exp_valid;
        logic [4:0]  exp_last;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    note_pattern_loader #(
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_byte         (i_byte),
        .i_byte_valid   (i_byte_valid),
        .o_byte_ready   (o_byte_ready),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .o_seq_hold     (o_seq_hold),
        .o_pattern_valid(o_pattern_valid),
        .o_pattern_last (o_pattern_last),
        .o_done_stb     (o_done_stb),
        .o_error        (o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: every write strobe must match the next queued entry.
    always @(negedge clk) begin
        if (o_done_stb) done_cnt++;
        if (o_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'(o_wr_addr), 32'hFFFF_FFFF);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(o_wr_addr), 32'(e[20:16]));
                chk("wr_data", 32'(o_wr_data), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Drives one byte and returns at the negedge after it was transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        i_byte = b;
        i_byte_valid = 1'b1;
        while (!o_byte_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) chk("ready_wait", 32'(o_byte_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(o_byte_ready), 32'd1);
        chk({tag, "_wr_en"}, 32'(o_wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(o_wr_data), 32'd0);
        chk({tag, "_hold"}, 32'(o_seq_hold), 32'd0);
        chk({tag, "_pvalid"}, 32'(o_pattern_valid), 32'd0);
        chk({tag, "_plast"}, 32'(o_pattern_last), 32'd0);
        chk({tag, "_done"}, 32'(o_done_stb), 32'd0);
        chk({tag, "_error"}, 32'(o_error), 32'd0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0]  sum;
        logic [15:0] e;
        int nw;
        nw = (v.n >= 8'd1 && v.n <= 8'd32) ? int'(v.n) : 0;
        done_cnt = 0;
        if (v.garbage) begin
            send_byte(8'h00, v.gaps);
            send_byte(8'hFF, v.gaps);
            send_byte(8'h12, v.gaps);
            chk("garbage_no_hold", 32'(o_seq_hold), 32'd0);
        end
        send_byte(8'hA5, v.gaps);
        chk("hold_after_sync", 32'(o_seq_hold), 32'd1);
        chk("valid_clr_on_sync", 32'(o_pattern_valid), 32'd0);
        send_byte(v.n, v.gaps);
        if (nw > 0) begin
            sum = v.n;
            for (int k = 0; k < nw; k++) begin
                e = v.base | 16'(k);
                sum = sum + e[7:0] + e[15:8];
                send_byte(e[7:0], v.gaps);
                exp_q.push_back({5'(k), e});
                send_byte(e[15:8], v.gaps);
                chk("wr_en_after_hi", 32'(o_wr_en), 32'd1);
                chk("ready_low_in_write", 32'(o_byte_ready), 32'd0);
            end
            chk("hold_before_csum", 32'(o_seq_hold), 32'd1);
            send_byte(sum + v.adj, v.gaps);
        end
        repeat (2) @(negedge clk);
        chk("writes_drained", 32'(exp_q.size()), 32'd0);
        chk("error", 32'(o_error), 32'(v.exp_err));
        chk("pattern_valid", 32'(o_pattern_valid), 32'(v.exp_valid));
        chk("pattern_last", 32'(o_pattern_last), 32'(v.exp_last));
        chk("done_pulses", 32'(done_cnt), 32'(v.exp_done));
        chk("hold_released", 32'(o_seq_hold), 32'd0);
        chk("idle_ready", 32'(o_byte_ready), 32'd1);
    endtask

    initial begin
        //          n      base      adj   garb gaps err  val  last  done
        vecs[0] = '{8'd1,  16'h0123, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1};
        vecs[1] = '{8'd32, 16'h0040, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1};
        vecs[2] = '{8'd0,  16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 0};
        vecs[3] = '{8'd33, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 0};
        vecs[4] = '{8'd1,  16'h0123, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1};
        vecs[5] = '{8'd4,  16'hF800, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  0};
        vecs[6] = '{8'd1,  16'h0123, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0,  1};
        vecs[7] = '{8'd2,  16'h00A5, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1,  1};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Stall after the count byte until the idle timeout fires.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (TOUT - 1) @(negedge clk);
        chk("tout_not_yet", 32'(o_error), 32'd0);
        chk("tout_hold_still", 32'(o_seq_hold), 32'd1);
        @(negedge clk);
        chk("tout_error", 32'(o_error), 32'd1);
        chk("tout_hold_off", 32'(o_seq_hold), 32'd0);
        chk("tout_idle_ready", 32'(o_byte_ready), 32'd1);
        chk("tout_last_kept", 32'(o_pattern_last), 32'd1);

        // Reset in the middle of the fourth entry of a 5-entry frame.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] e;
            e = 16'h0300 | 16'(k);
            send_byte(e[7:0], 1'b0);
            exp_q.push_back({5'(k), e});
            send_byte(e[15:8], 1'b0);
        end
        send_byte(8'h03, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        i_byte = 8'h03;
        i_byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        i_byte_valid = 1'b0;
        chk("midrst_no_writes", 32'(exp_q.size()), 32'd0);
        chk("midrst_still_idle", 32'(o_seq_hold), 32'd0);

        // A clean frame loads normally after the reset.
        run_frame(vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
